// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the serial link receive side: FSM state type,
// default word width and the bit counter width helper.
package s2p_pkg;

    // Default word width, shared with the parallel-to-serial transmitter.
    localparam int S2P_DATA_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } s2p_state_e;

    // The counter must be able to hold values 0 through data_w.
    function automatic int s2p_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel_if.sv
// Serial link bundle: bit stream in, assembled word out over valid/ready,
// plus sticky error status. The slave modport is the receiver's view.
interface s2p_if #(
    parameter int DATA_W = s2p_pkg::S2P_DATA_W
) ();

    logic              serial_in;
    logic              bit_en;
    logic              start;
    logic [DATA_W-1:0] parallel_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overrun;
    logic              frame_err;
    logic              clear_err;

    modport master (
        output serial_in, bit_en, start, out_ready, clear_err,
        input  parallel_out, out_valid, busy, overrun, frame_err
    );

    modport slave (
        input  serial_in, bit_en, start, out_ready, clear_err,
        output parallel_out, out_valid, busy, overrun, frame_err
    );

endinterface

// File: rtl/serial_to_parallel.sv
// Deserializer for the single-bit serial link: frames words on a start strobe,
// counts bits, and hands each completed word out through one holding register.
module serial_to_parallel
    import s2p_pkg::*;
#(
    parameter int DATA_W    = S2P_DATA_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    s2p_if.slave  link
);

    localparam int CNT_W = s2p_cnt_w(DATA_W);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    s2p_state_e state_q, state_d;
    cnt_t       cnt_q,   cnt_d;
    word_t      shreg_q, shreg_d;
    word_t      pout_q,  pout_d;
    logic       vld_q,   vld_d;
    logic       ovr_q,   ovr_d;
    logic       ferr_q,  ferr_d;

    logic       accept;
    logic       complete;
    logic       ovr_set;
    logic       ferr_set;
    word_t      word_c;

    // One-hot mask for the register position of received bit k.
    function automatic word_t bit_mask(input cnt_t k);
        int unsigned pos;
        if (MSB_FIRST) begin
            pos = DATA_W - 1 - 32'(k);
        end else begin
            pos = 32'(k);
        end
        return word_t'(1) << pos;
    endfunction

    assign accept = vld_q & link.out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        complete = 1'b0;
        ferr_set = 1'b0;
        word_c   = shreg_q;

        unique case (state_q)
            IDLE: begin
                if (link.bit_en && link.start) begin
                    shreg_d = link.serial_in ? bit_mask(cnt_t'(0)) : '0;
                    cnt_d   = cnt_t'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (link.bit_en) begin
                    if (link.start) begin
                        // Resync: the partial word is abandoned, this bit starts afresh.
                        ferr_set = 1'b1;
                        shreg_d  = link.serial_in ? bit_mask(cnt_t'(0)) : '0;
                        cnt_d    = cnt_t'(1);
                    end else begin
                        word_c = link.serial_in ? (shreg_q | bit_mask(cnt_q)) : shreg_q;
                        if (cnt_q == cnt_t'(DATA_W - 1)) begin
                            complete = 1'b1;
                            shreg_d  = '0;
                            cnt_d    = '0;
                            state_d  = IDLE;
                        end else begin
                            shreg_d  = word_c;
                            cnt_d    = cnt_q + cnt_t'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // Holding register: a finished word loads if the slot is free or is
    // being emptied this very edge; otherwise it is dropped as an overrun.
    always_comb begin
        pout_d  = pout_q;
        vld_d   = vld_q;
        ovr_set = 1'b0;

        if (complete) begin
            if (!vld_q || accept) begin
                pout_d = word_c;
                vld_d  = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (accept) begin
            vld_d = 1'b0;
        end
    end

    // Setting a sticky flag takes priority over clearing it.
    always_comb begin
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (link.clear_err) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
        if (ferr_set) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            pout_q  <= '0;
            vld_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            vld_q   <= vld_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign link.parallel_out = pout_q;
    assign link.out_valid    = vld_q;
    assign link.busy         = (state_q == SHIFT);
    assign link.overrun      = ovr_q;
    assign link.frame_err    = ferr_q;

endmodule
